uart_fifo: RTL and testbench



---
 rtl/uart_fifo.sv | 121 ++++++++++++
 tb/tb_uart_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Single-clock character FIFO for the UART Rx/Tx paths, with occupancy and threshold status.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module uart_fifo #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("uart_fifo: DEPTH must equal 2**ADDR_W");
    end
    if (AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("uart_fifo: AFULL_THRESH must not exceed DEPTH");
    end
    if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
        $error("uart_fifo: AEMPTY_THRESH must be below DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full_o && !pop_i) begin
                overflow_q <= 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the write strobe is gated by reset/flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && push_ok) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];
`else
    logic [DATA_W-1:0] rd_data_q;

    // Nonblocking read of mem gives read-before-write when full with push and pop together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (!clear_i && pop_ok) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

    assign count_o        = count_q;
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: queue-based reference model checked every cycle, plus directed literal checks.
// Honours UART_FIFO_FWFT_EN the same way the design does.
module tb_uart_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clear_i = 1'b0;
    logic       push_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       pop_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       full_o, empty_o, almost_full_o, almost_empty_o;
    logic [4:0] count_o;
    logic       overflow_o, underflow_o;

    int total = 0;
    int bad   = 0;

    uart_fifo dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .push_i         (push_i),
        .wr_data_i      (wr_data_i),
        .pop_i          (pop_i),
        .rd_data_o      (rd_data_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of characters plus sticky flags.
    logic [7:0] mq[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mq.delete();
            m_rd  <= 8'h00;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else if (clear_i) begin
            mq.delete();
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            automatic bit was_full  = (mq.size() == 16);
            automatic bit was_empty = (mq.size() == 0);
            if (pop_i && was_empty) m_unf <= 1'b1;
            if (push_i && was_full && !pop_i) m_ovf <= 1'b1;
            if (pop_i && !was_empty) m_rd <= mq.pop_front();
            if (push_i && (!was_full || pop_i)) mq.push_back(wr_data_i);
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            automatic int n = mq.size();
            automatic logic [7:0] exp_rd;
`ifdef UART_FIFO_FWFT_EN
            exp_rd = (n != 0) ? mq[0] : 8'h00;
`else
            exp_rd = m_rd;
`endif
            chk("count", count_o, n);
            chk("full", full_o, n == 16);
            chk("empty", empty_o, n == 0);
            chk("almost_full", almost_full_o, n >= 12);
            chk("almost_empty", almost_empty_o, n <= 4);
            chk("overflow", overflow_o, m_ovf);
            chk("underflow", underflow_o, m_unf);
            chk("rd_data", rd_data_o, exp_rd);
        end
    end

    task automatic cyc(input logic p, input logic [7:0] d, input logic po,
                       input logic c, input logic r);
        push_i    = p;
        wr_data_i = d;
        pop_i     = po;
        clear_i   = c;
        rst_i     = r;
        @(negedge clk_i);
        push_i  = 1'b0;
        pop_i   = 1'b0;
        clear_i = 1'b0;
        rst_i   = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp, input logic p, input logic [7:0] d,
                              input string nm);
`ifdef UART_FIFO_FWFT_EN
        chk(nm, rd_data_o, exp);
        cyc(p, d, 1'b1, 1'b0, 1'b0);
`else
        cyc(p, d, 1'b1, 1'b0, 1'b0);
        chk(nm, rd_data_o, exp);
`endif
    endtask

    initial begin
        @(negedge clk_i);
        cyc(0, 8'h00, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);

        // reset state
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_aempty", almost_empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_rd", rd_data_o, 8'h00);
        chk("rst_flags", {overflow_o, underflow_o}, 2'b00);

        // fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            if (i == 4)  chk("aempty_at4", almost_empty_o, 1);
            if (i == 5)  chk("aempty_at5", almost_empty_o, 0);
            if (i == 11) chk("afull_at11", almost_full_o, 0);
            if (i == 12) chk("afull_at12", almost_full_o, 1);
        end
        chk("fill_full", full_o, 1);
        chk("fill_count", count_o, 16);
        cyc(1, 8'hAA, 0, 0, 0);
        chk("ovf_set", overflow_o, 1);
        chk("ovf_count", count_o, 16);
        for (int i = 1; i <= 16; i++) pop_expect(8'(i), 0, 8'h00, "drain1");
        chk("drain1_empty", empty_o, 1);
        chk("ovf_sticky", overflow_o, 1);
        cyc(0, 8'h00, 0, 1, 0);
        chk("clr_ovf", overflow_o, 0);

        // push + pop on empty
        cyc(1, 8'h55, 1, 0, 0);
        chk("pp_empty_count", count_o, 1);
        chk("pp_empty_unf", underflow_o, 1);
        pop_expect(8'h55, 0, 8'h00, "pp_empty_data");
        cyc(0, 8'h00, 0, 1, 0);

        // full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            automatic logic [7:0] e = (i < 16) ? 8'(8'h20 + i) : 8'(8'h80 + i - 16);
            pop_expect(e, 1, 8'(8'h80 + i), "wrap_data");
            chk("wrap_count", count_o, 16);
        end
        chk("wrap_no_ovf", overflow_o, 0);
        for (int i = 4; i < 20; i++) pop_expect(8'(8'h80 + i), 0, 8'h00, "wrap_drain");

        // clear with a concurrent push
        cyc(0, 8'h00, 1, 1, 0);
        cyc(0, 8'h00, 1, 0, 0);
        chk("pre_clr_unf", underflow_o, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
        cyc(1, 8'hEE, 0, 1, 0);
        chk("clr_count", count_o, 0);
        chk("clr_empty", empty_o, 1);
        chk("clr_flags", {overflow_o, underflow_o}, 2'b00);

        // single word into an empty FIFO
        cyc(1, 8'h3C, 0, 0, 0);
`ifdef UART_FIFO_FWFT_EN
        chk("fwft_visible", rd_data_o, 8'h3C);
        cyc(0, 8'h00, 1, 0, 0);
        chk("fwft_empty", empty_o, 1);
        chk("fwft_zero", rd_data_o, 8'h00);
`else
        pop_expect(8'h3C, 0, 8'h00, "reg_3c");
        chk("reg_3c_empty", empty_o, 1);
`endif

        // reset during a push discards it
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 1, 0, 1);
        chk("rst_mid_count", count_o, 0);
        chk("rst_mid_rd", rd_data_o, 8'h00);
        cyc(0, 8'h00, 0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
